// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: wavefront slot geometry and the scheduler
// FSM encoding, also used by the PC storage and the instruction buffer.
package fetch_pkg;

    localparam int NUM_WF      = 40;
    localparam int WF_ID_W     = 6;
    localparam int MAX_OUT_DEF = 4;

    typedef logic [WF_ID_W-1:0] wf_id_t;
    typedef logic [0:0]         fsm_state_t;

    localparam fsm_state_t ST_IDLE = 1'b0;
    localparam fsm_state_t ST_REQ  = 1'b1;

    function automatic logic wf_id_valid(input wf_id_t id);
        return int'(id) < NUM_WF;
    endfunction

endpackage

// File: rtl/fetch_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit strictly
// after ptr_i, wrapping from N-1 to 0, using a doubled request mask.
module rr_pick
    import fetch_pkg::*;
#(
    parameter int N    = NUM_WF,
    parameter int ID_W = WF_ID_W
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            found_o,
    output logic [ID_W-1:0] id_o
);

    logic [2*N-1:0] req_dbl;

    assign req_dbl = {req_i, req_i};

    // Scan downward so the lowest index inside the window (ptr, ptr+N] wins.
    always_comb begin
        found_o = 1'b0;
        id_o    = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (req_dbl[i] && (i > int'(ptr_i)) && (i <= int'(ptr_i) + N)) begin
                found_o = 1'b1;
                id_o    = (i >= N) ? ID_W'(i - N) : ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/fetch_scheduler.sv
// Fetch-stage wavefront scheduler: round-robin selection of an eligible
// wavefront, valid/ready request to instruction memory, in-flight fetch cap.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | arbitrate among eligible wavefronts if below the in-flight cap
//   REQ     | request for grant held on memory port until ready
module fetch_scheduler
    import fetch_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wf_alloc_valid,
    input  logic [WF_ID_W-1:0] wf_alloc_id,
    input  logic               wf_dealloc_valid,
    input  logic [WF_ID_W-1:0] wf_dealloc_id,
    input  logic [NUM_WF-1:0]  ibuff_full,
    input  logic [NUM_WF-1:0]  wf_stall,
    output logic               fetch_req_valid,
    input  logic               fetch_req_ready,
    output logic [WF_ID_W-1:0] fetch_req_wf_id,
    output logic [WF_ID_W-1:0] pc_rd_wf_id,
    output logic               pc_rd_en,
    input  logic               fetch_ack,
    input  logic [WF_ID_W-1:0] fetch_ack_wf_id,
    output logic               busy,
    output logic               err
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    fsm_state_t        state_q, state_d;
    wf_id_t            grant_q, grant_d;
    wf_id_t            rr_ptr_q, rr_ptr_d;
    logic [NUM_WF-1:0] active_q, active_d;
    logic [NUM_WF-1:0] pending_q, pending_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic              err_q, err_d;

    logic [NUM_WF-1:0] eligible;
    logic              pick_found;
    wf_id_t            pick_id;
    logic              handshake;
    logic              alloc_ok;
    logic              dealloc_ok;
    logic              ack_hit;
    logic              can_issue;

    assign eligible   = active_q & ~pending_q & ~ibuff_full & ~wf_stall;
    assign handshake  = (state_q == ST_REQ) && fetch_req_ready;
    assign alloc_ok   = wf_alloc_valid && wf_id_valid(wf_alloc_id);
    assign dealloc_ok = wf_dealloc_valid && wf_id_valid(wf_dealloc_id);
    assign ack_hit    = fetch_ack && wf_id_valid(fetch_ack_wf_id) && pending_q[fetch_ack_wf_id];
    assign can_issue  = pick_found && (outstanding_q < OUT_W'(MAX_OUT));

    rr_pick #(
        .N    (NUM_WF),
        .ID_W (WF_ID_W)
    ) u_rr_pick (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .id_o    (pick_id)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (can_issue) begin
                    grant_d  = pick_id;
                    rr_ptr_d = pick_id;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fetch_req_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Alloc is applied after dealloc so a same-id collision leaves the slot active.
    always_comb begin
        active_d = active_q;
        if (dealloc_ok) begin
            active_d[wf_dealloc_id] = 1'b0;
        end
        if (alloc_ok) begin
            active_d[wf_alloc_id] = 1'b1;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (ack_hit) begin
            pending_d[fetch_ack_wf_id] = 1'b0;
        end
        if (handshake) begin
            pending_d[grant_q] = 1'b1;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({handshake, ack_hit})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    assign err_d = err_q | (fetch_ack & ~ack_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= WF_ID_W'(NUM_WF - 1);
            active_q      <= '0;
            pending_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign fetch_req_valid = (state_q == ST_REQ);
    assign fetch_req_wf_id = grant_q;
    assign pc_rd_wf_id     = grant_q;
    assign pc_rd_en        = handshake;
    assign busy            = (outstanding_q != '0) || (state_q == ST_REQ);
    assign err             = err_q;

endmodule

// File: tb/tb_fetch_scheduler.sv
// Self-checking bench for fetch_scheduler: expected request ids are queued as
// stimulus is applied and compared when the memory handshake is observed.
module tb_fetch_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wf_alloc_valid = 1'b0;
    logic [5:0]  wf_alloc_id = '0;
    logic        wf_dealloc_valid = 1'b0;
    logic [5:0]  wf_dealloc_id = '0;
    logic [39:0] ibuff_full = '0;
    logic [39:0] wf_stall = '0;
    logic        fetch_req_valid;
    logic        fetch_req_ready = 1'b0;
    logic [5:0]  fetch_req_wf_id;
    logic [5:0]  pc_rd_wf_id;
    logic        pc_rd_en;
    logic        fetch_ack = 1'b0;
    logic [5:0]  fetch_ack_wf_id = '0;
    logic        busy;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          base = 0;
    logic [5:0]  exp_q[$];

    fetch_scheduler #(.MAX_OUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .wf_alloc_valid   (wf_alloc_valid),
        .wf_alloc_id      (wf_alloc_id),
        .wf_dealloc_valid (wf_dealloc_valid),
        .wf_dealloc_id    (wf_dealloc_id),
        .ibuff_full       (ibuff_full),
        .wf_stall         (wf_stall),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_req_wf_id  (fetch_req_wf_id),
        .pc_rd_wf_id      (pc_rd_wf_id),
        .pc_rd_en         (pc_rd_en),
        .fetch_ack        (fetch_ack),
        .fetch_ack_wf_id  (fetch_ack_wf_id),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake happens at the next posedge; sampled on the negedge before it.
    task automatic monitor();
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fetch_req_valid && fetch_req_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check("hs_unexpected_id", 64'(fetch_req_wf_id), 64'hdead);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_id", 64'(fetch_req_wf_id), 64'(e));
                        check("pc_rd_id", 64'(pc_rd_wf_id), 64'(e));
                        check("pc_rd_en_hs", 64'(pc_rd_en), 64'(1));
                    end
                end else if (pc_rd_en) begin
                    check("pc_rd_en_stray", 64'(pc_rd_en), 64'(0));
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wf_alloc_valid = 1'b0;
        wf_dealloc_valid = 1'b0;
        fetch_ack = 1'b0;
        fetch_req_ready = 1'b0;
        ibuff_full = '0;
        wf_stall = '0;
        repeat (2) tick();
        exp_q.delete();
        rst = 1'b0;
        tick();
        base = hs_count;
    endtask

    task automatic alloc(input int id);
        wf_alloc_id = 6'(id);
        wf_alloc_valid = 1'b1;
        tick();
        wf_alloc_valid = 1'b0;
    endtask

    task automatic ack(input int id);
        fetch_ack_wf_id = 6'(id);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        check("hs_count", 64'(hs_count), 64'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(fetch_req_valid), 64'(0));
        check({tag, "_rd_en"}, 64'(pc_rd_en), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_req_id"}, 64'(fetch_req_wf_id), 64'(0));
        check({tag, "_pc_id"}, 64'(pc_rd_wf_id), 64'(0));
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Round-robin order 0, 5, 39, then 0 again once its fetch is acked.
        do_reset();
        check_idle_outputs("reset");
        fetch_req_ready = 1'b1;
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd5);
        exp_q.push_back(6'd39);
        exp_q.push_back(6'd0);
        alloc(0);
        alloc(5);
        alloc(39);
        wait_hs(base + 3, 20);
        ack(0);
        wait_hs(base + 4, 20);
        check("t1_drained", 64'(exp_q.size()), 64'(0));

        // Request held stable under backpressure and ibuff_full.
        do_reset();
        exp_q.push_back(6'd5);
        alloc(5);
        tick();
        ibuff_full[5] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_valid", 64'(fetch_req_valid), 64'(1));
            check("t2_hold_id", 64'(fetch_req_wf_id), 64'(5));
            check("t2_hold_rd_en", 64'(pc_rd_en), 64'(0));
            tick();
        end
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready = 1'b0;
        check("t2_after_valid", 64'(fetch_req_valid), 64'(0));
        check("t2_drained", 64'(exp_q.size()), 64'(0));
        ibuff_full = '0;

        // Outstanding cap of 4, then one ack frees a slot; pending ones skipped.
        do_reset();
        fetch_req_ready = 1'b1;
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd2);
        exp_q.push_back(6'd3);
        exp_q.push_back(6'd4);
        alloc(1);
        alloc(2);
        alloc(3);
        alloc(4);
        alloc(6);
        alloc(8);
        repeat (12) tick();
        check("t3_cap_hs", 64'(hs_count - base), 64'(4));
        check("t3_cap_valid", 64'(fetch_req_valid), 64'(0));
        check("t3_cap_busy", 64'(busy), 64'(1));
        exp_q.push_back(6'd6);
        ack(1);
        check("t3_ack_k1_valid", 64'(fetch_req_valid), 64'(0));
        tick();
        check("t3_ack_k2_valid", 64'(fetch_req_valid), 64'(1));
        check("t3_ack_k2_id", 64'(fetch_req_wf_id), 64'(6));
        repeat (6) tick();
        check("t3_drained", 64'(exp_q.size()), 64'(0));

        // Handshake (7) and ack (2) in the same cycle keep the count unchanged.
        do_reset();
        fetch_req_ready = 1'b1;
        exp_q.push_back(6'd2);
        alloc(2);
        wait_hs(base + 1, 10);
        fetch_req_ready = 1'b0;
        exp_q.push_back(6'd7);
        alloc(7);
        tick();
        check("t4_req_valid", 64'(fetch_req_valid), 64'(1));
        check("t4_req_id", 64'(fetch_req_wf_id), 64'(7));
        fetch_req_ready = 1'b1;
        fetch_ack_wf_id = 6'd2;
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        exp_q.push_back(6'd2);
        exp_q.push_back(6'd10);
        exp_q.push_back(6'd11);
        alloc(10);
        alloc(11);
        alloc(12);
        repeat (8) tick();
        check("t4_drained", 64'(exp_q.size()), 64'(0));
        check("t4_cap_valid", 64'(fetch_req_valid), 64'(0));
        check("t4_busy", 64'(busy), 64'(1));
        check("t4_err", 64'(err), 64'(0));

        // Dealloc during REQ, completion, no regrant, then spurious ack sets err.
        do_reset();
        exp_q.push_back(6'd3);
        alloc(3);
        tick();
        check("t5_req_id", 64'(fetch_req_wf_id), 64'(3));
        wf_dealloc_id = 6'd3;
        wf_dealloc_valid = 1'b1;
        tick();
        wf_dealloc_valid = 1'b0;
        check("t5_held_valid", 64'(fetch_req_valid), 64'(1));
        check("t5_held_id", 64'(fetch_req_wf_id), 64'(3));
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready = 1'b0;
        check("t5_done_valid", 64'(fetch_req_valid), 64'(0));
        ack(3);
        check("t5_ack_err", 64'(err), 64'(0));
        check("t5_ack_busy", 64'(busy), 64'(0));
        fetch_req_ready = 1'b1;
        repeat (6) tick();
        check("t5_no_regrant", 64'(fetch_req_valid), 64'(0));
        ack(9);
        check("t5_err_set", 64'(err), 64'(1));
        repeat (3) tick();
        check("t5_err_sticky", 64'(err), 64'(1));
        exp_q.push_back(6'd3);
        alloc(3);
        wait_hs(base + 2, 10);

        // Asynchronous reset in REQ, out-of-range ids, first-grant latency.
        do_reset();
        exp_q.push_back(6'd0);
        alloc(0);
        tick();
        check("t6_req_valid", 64'(fetch_req_valid), 64'(1));
        ack(9);
        check("t6_err_before", 64'(err), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_async_rst");
        exp_q.delete();
        #1;
        rst = 1'b0;
        tick();
        base = hs_count;
        fetch_req_ready = 1'b1;
        alloc(45);
        repeat (3) tick();
        check("t6_oor_alloc_valid", 64'(fetch_req_valid), 64'(0));
        check("t6_oor_alloc_busy", 64'(busy), 64'(0));
        ack(50);
        check("t6_oor_ack_err", 64'(err), 64'(1));
        exp_q.push_back(6'd0);
        alloc(0);
        check("t6_lat1_valid", 64'(fetch_req_valid), 64'(0));
        tick();
        check("t6_lat2_valid", 64'(fetch_req_valid), 64'(1));
        check("t6_lat2_id", 64'(fetch_req_wf_id), 64'(0));
        wait_hs(base + 1, 5);
        check("t6_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_scheduler.md
# fetch_scheduler

Selects which wavefront fetches next and sequences the per-wavefront PC storage in the fetch stage. Tracks allocated and pending wavefronts, picks an eligible one round-robin, and issues a valid/ready fetch request to instruction memory. On handshake it pulses the PC-storage read-advance. It caps total outstanding fetches and retires them on memory acknowledge.

## Interface
- NUM_WF, 40: wavefront slots.
- WF_ID_W, 6: wavefront id width.
- MAX_OUT, 4: maximum in-flight fetches, range 1..NUM_WF.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wf_alloc_valid  in  1  new wavefront dispatched; the same pulse writes its initial PC into PC storage.
- wf_alloc_id  in  WF_ID_W  slot allocated.
- wf_dealloc_valid  in  1  wavefront finished.
- wf_dealloc_id  in  WF_ID_W  slot freed.
- ibuff_full  in  NUM_WF  per-wavefront instruction buffer has no room.
- wf_stall  in  NUM_WF  per-wavefront fetch hold (branch/barrier pending).
- fetch_req_valid  out  1  fetch request to instruction memory.
- fetch_req_ready  in  1  memory accepts the request.
- fetch_req_wf_id  out  WF_ID_W  wavefront of the request.
- pc_rd_wf_id  out  WF_ID_W  PC-storage read select.
  - Memory takes its address combinationally from PC-storage output bits [31:0].
  - Bit 32 is the first-fetch flag.
- pc_rd_en  out  1  PC-storage advance; equals fetch_req_valid & fetch_req_ready.
- fetch_ack  in  1  memory returned a fetch.
- fetch_ack_wf_id  in  WF_ID_W  wavefront of the returned fetch.
- busy  out  1  outstanding count nonzero or state is REQ.
- err  out  1  sticky: ack received for a non-pending wavefront.

## Operation
- State per slot: active[NUM_WF], pending[NUM_WF]. Global state: outstanding counter (width clog2(MAX_OUT+1)), rr_ptr, grant.
- Eligible = active & ~pending & ~ibuff_full & ~wf_stall.
- FSM states:
  - IDLE: if eligible is nonzero and outstanding < MAX_OUT:
    - grant ← first eligible id, searching upward from rr_ptr+1 and wrapping from NUM_WF-1 to 0.
    - rr_ptr ← grant.
    - go to REQ.
  - REQ: fetch_req_valid=1 and fetch_req_wf_id=grant.
    - On fetch_req_ready: pending[grant] ← 1, outstanding +1, go to IDLE.
    - Valid and id are held stable until ready. Eligibility changes and dealloc of grant do not withdraw the request.
- pc_rd_wf_id = grant in all states. pc_rd_en is asserted only on the handshake cycle.
- Alloc: active[id] ← 1. Pending is untouched; a reallocated slot with a fetch in flight stays ineligible until that fetch is acked.
- Dealloc: active[id] ← 0. Pending is cleared only by ack.
- Alloc and dealloc of the same id in the same cycle: alloc wins.
- Ack with pending[id]=1: pending[id] ← 0, outstanding −1.
- Ack with pending[id]=0: ignored (count unchanged), err ← 1.
- Handshake and ack in the same cycle: net outstanding change is 0. Both bit updates apply.
- Ids ≥ NUM_WF on alloc, dealloc or ack are ignored; an ack with such an id also sets err.

## Timing
- Reset values:
  - fetch_req_valid=0, pc_rd_en=0, busy=0, err=0.
  - grant=0, so fetch_req_wf_id=pc_rd_wf_id=0.
  - rr_ptr=NUM_WF-1, so the first search starts at id 0.
  - active=pending=0, outstanding=0, state IDLE.
- Reset asserted mid-REQ drops fetch_req_valid immediately (asynchronous) and discards all pending and count state.
- Alloc, dealloc and ack take effect on the next edge; a wavefront allocated in cycle N is eligible for arbitration in cycle N+1.
- Arbitration evaluated in IDLE at cycle N gives fetch_req_valid=1 in cycle N+1.
- Handshake in cycle M returns the FSM to IDLE in M+1; the next valid is earliest M+2. Peak rate is one fetch per 2 cycles.
- ibuff_full and wf_stall are sampled only in IDLE.
- At outstanding=MAX_OUT there is no grant. An ack in cycle K allows a grant in IDLE at K+1.

## Structure
- Shared package fetch_pkg holds NUM_WF, WF_ID_W and the FSM state enum (IDLE, REQ), which are shared with the PC storage and the ibuffer.
- Sub-module rr_pick: a combinational round-robin picker.
  - Inputs: NUM_WF-bit request mask and WF_ID_W pointer.
  - Outputs: found and id.
  - Implemented as a doubled-mask priority search.

## Test plan
- Reset, then alloc wf 0, 5 and 39 with ready tied high → requests issued in order 0, 5, 39, 0; each pc_rd_en pulse one cycle with pc_rd_wf_id matching.
- Hold ready low 3 cycles in REQ with grant 5, and raise ibuff_full[5] → valid and id 5 held stable; a single pc_rd_en on the ready cycle.
- MAX_OUT=4, alloc 6 wavefronts, no acks → exactly 4 handshakes, then IDLE with busy=1. Ack wf 1 → next grant within 2 cycles, skipping pending slots.
- Handshake for wf 7 and ack for wf 2 in the same cycle → outstanding unchanged; pending[7]=1 and pending[2]=0.
- Dealloc wf 3 during REQ grant 3, then ack 3 → request completes and pending clears; wf 3 never granted again until realloc. Then ack wf 9 while not pending → err=1 and stays set.
- Assert rst in REQ → fetch_req_valid=0 the same cycle; all outputs at reset values. First grant after alloc of wf 0 occurs 2 cycles after the alloc pulse.
